// File: rtl/pit_data_responder_if.sv
// FIB <-> PIT data-propagation handshake bundle: interest insert, prefix query/response, payload stream.
interface pit_data_responder_if #(
  parameter int unsigned PREFIX_W = 64,
  parameter int unsigned LEN_W    = 6
);
  logic                interest_valid;
  logic [PREFIX_W-1:0] interest_prefix;
  logic [LEN_W-1:0]    interest_len;
  logic                interest_ready;
  logic                prefix_ready;
  logic [PREFIX_W-1:0] fib_prefix;
  logic [LEN_W-1:0]    fib_len;
  logic                rejected;
  logic                start_send_to_pit;
  logic [7:0]          fib_data;
  logic [7:0]          data_out;
  logic                data_out_valid;
  logic                data_out_last;

  modport master (
    output interest_valid, interest_prefix, interest_len,
    output prefix_ready, fib_prefix, fib_len, fib_data,
    input  interest_ready, rejected, start_send_to_pit,
    input  data_out, data_out_valid, data_out_last
  );

  modport slave (
    input  interest_valid, interest_prefix, interest_len,
    input  prefix_ready, fib_prefix, fib_len, fib_data,
    output interest_ready, rejected, start_send_to_pit,
    output data_out, data_out_valid, data_out_last
  );
endinterface

// File: rtl/pit_data_responder.sv
// PIT-side responder: pending-interest table, FIB query accept/reject and payload forwarding.
// Optional PIT_REJECT_CNT_EN adds a saturating 16-bit rejected-query counter.
module pit_data_responder #(
  parameter int unsigned ENTRIES    = 8,
  parameter int unsigned DATA_BYTES = 1024,
  parameter int unsigned PREFIX_W   = 64,
  parameter int unsigned LEN_W      = 6
) (
  input  logic                clk,
  input  logic                rst,
  pit_data_responder_if.slave bus,
  output logic                table_full,
  output logic                busy,
  output logic [15:0]         reject_count
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W = $clog2(DATA_BYTES) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND, RECEIVE} state_t;

  state_t              state;
  logic [ENTRIES-1:0]  valid;
  logic [PREFIX_W-1:0] tab_prefix [ENTRIES];
  logic [LEN_W-1:0]    tab_len    [ENTRIES];
  logic [PREFIX_W-1:0] q_prefix;
  logic [LEN_W-1:0]    q_len;
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [CNT_W-1:0]    cnt;
  logic                rejected_r;
  logic                start_r;
  logic [7:0]          dout_r;
  logic                dout_valid_r;
  logic                dout_last_r;

  logic                ins_dup;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic                lk_hit;
  logic [IDX_W-1:0]    lk_idx;
  logic                ins_take;
  logic                retire;

  always_comb begin
    ins_dup    = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    lk_hit     = 1'b0;
    lk_idx     = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tab_len[i] == bus.interest_len && tab_prefix[i] == bus.interest_prefix)
        ins_dup = 1'b1;
      if (!valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (valid[i] && tab_len[i] == q_len && tab_prefix[i] == q_prefix && !lk_hit) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
    end
  end

  assign table_full = &valid;
  // free slot is chosen from pre-retirement valid bits, so a full table refuses an insert even on a retiring edge
  assign ins_take   = bus.interest_valid && free_found && !ins_dup;
  assign retire     = (state == RECEIVE) && (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (ins_take) valid[free_idx] <= 1'b1;
      if (retire)   valid[hit_idx]  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ins_take) begin
      tab_prefix[free_idx] <= bus.interest_prefix;
      tab_len[free_idx]    <= bus.interest_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      q_prefix     <= '0;
      q_len        <= '0;
      hit          <= 1'b0;
      hit_idx      <= '0;
      cnt          <= '0;
      rejected_r   <= 1'b0;
      start_r      <= 1'b0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      dout_last_r  <= 1'b0;
    end else begin
      rejected_r   <= 1'b0;
      start_r      <= 1'b0;
      dout_valid_r <= 1'b0;
      dout_last_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.prefix_ready) begin
            q_prefix <= bus.fib_prefix;
            q_len    <= bus.fib_len;
            state    <= LOOKUP;
            busy     <= 1'b1;
          end
        end
        LOOKUP: begin
          hit     <= lk_hit;
          hit_idx <= lk_idx;
          state   <= RESPOND;
        end
        RESPOND: begin
          if (hit) begin
            start_r <= 1'b1;
            cnt     <= '0;
            state   <= RECEIVE;
          end else begin
            rejected_r <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        RECEIVE: begin
          dout_r       <= bus.fib_data;
          dout_valid_r <= 1'b1;
          if (cnt == LAST_CNT) begin
            dout_last_r <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.interest_ready    = !table_full;
  assign bus.rejected          = rejected_r;
  assign bus.start_send_to_pit = start_r;
  assign bus.data_out          = dout_r;
  assign bus.data_out_valid    = dout_valid_r;
  assign bus.data_out_last     = dout_last_r;

`ifdef PIT_REJECT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reject_count <= '0;
    end else if (rejected_r && reject_count != '1) begin
      reject_count <= reject_count + 1'b1;
    end
  end
`else
  assign reject_count = '0;
`endif

endmodule

// File: tb/tb_pit_data_responder.sv
// Randomized bench for pit_data_responder against a transaction-level pending-interest table model.
module tb_pit_data_responder;
  localparam int unsigned ENTRIES    = 8;
  localparam int unsigned DATA_BYTES = 1024;
  localparam int unsigned PREFIX_W   = 64;
  localparam int unsigned LEN_W      = 6;
  localparam int unsigned POOL       = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        table_full;
  logic        busy;
  logic [15:0] reject_count;

  pit_data_responder_if #(.PREFIX_W(PREFIX_W), .LEN_W(LEN_W)) bus ();

  pit_data_responder #(
    .ENTRIES(ENTRIES), .DATA_BYTES(DATA_BYTES), .PREFIX_W(PREFIX_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .table_full(table_full), .busy(busy), .reject_count(reject_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the set of pending interests held in a slot-indexed array.
  logic [PREFIX_W-1:0] m_prefix [ENTRIES];
  logic [LEN_W-1:0]    m_len    [ENTRIES];
  bit                  m_valid  [ENTRIES];
  int unsigned         m_rejects = 0;

  logic [PREFIX_W-1:0] pool_p [POOL];
  logic [LEN_W-1:0]    pool_l [POOL];

  function automatic int model_find(input logic [PREFIX_W-1:0] p, input logic [LEN_W-1:0] l);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_prefix[i] == p && m_len[i] == l) return i;
    return -1;
  endfunction

  function automatic int model_free();
    for (int i = 0; i < ENTRIES; i++)
      if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic void model_insert(input logic [PREFIX_W-1:0] p, input logic [LEN_W-1:0] l);
    int f;
    if (model_find(p, l) >= 0) return;
    f = model_free();
    if (f < 0) return;
    m_valid[f]  = 1'b1;
    m_prefix[f] = p;
    m_len[f]    = l;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_rejects = 0;
  endfunction

  function automatic logic [15:0] exp_rc();
`ifdef PIT_REJECT_CNT_EN
    return (m_rejects > 16'hFFFF) ? 16'hFFFF : 16'(m_rejects);
`else
    return 16'h0000;
`endif
  endfunction

  // FIB payload source and downstream checker.
  logic [7:0]  exp_q [$];
  logic [7:0]  drv_b;
  logic [7:0]  exp_b;
  bit          tx_active = 1'b0;
  bit          seq_mode  = 1'b0;
  int unsigned tx_idx    = 0;
  int unsigned rx_count  = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      tx_active    = 1'b0;
      rx_count     = 0;
      bus.fib_data = '0;
    end else begin
      if (bus.data_out_valid) begin
        rx_count++;
        if (exp_q.size() == 0) begin
          check("data_unexpected", 64'(rx_count), 64'd0);
        end else begin
          exp_b = exp_q.pop_front();
          check("data_out", bus.data_out, exp_b);
        end
        check("data_out_last", bus.data_out_last, rx_count == DATA_BYTES);
      end
      if (bus.start_send_to_pit) begin
        tx_active = 1'b1;
        tx_idx    = 0;
        rx_count  = 0;
      end
      if (tx_active) begin
        drv_b = seq_mode ? 8'(tx_idx) : 8'($urandom);
        bus.fib_data = drv_b;
        exp_q.push_back(drv_b);
        tx_idx++;
        if (tx_idx == DATA_BYTES) tx_active = 1'b0;
      end
    end
  end

  task automatic tick(input bit ins, input logic [PREFIX_W-1:0] ip, input logic [LEN_W-1:0] il,
                      input bit qry, input logic [PREFIX_W-1:0] qp, input logic [LEN_W-1:0] ql);
    if (ins) check("interest_ready", bus.interest_ready, model_free() >= 0);
    bus.interest_valid  = ins;
    bus.interest_prefix = ip;
    bus.interest_len    = il;
    bus.prefix_ready    = qry;
    bus.fib_prefix      = qp;
    bus.fib_len         = ql;
    @(negedge clk);
    if (ins) model_insert(ip, il);
    bus.interest_valid = 1'b0;
    bus.prefix_ready   = 1'b0;
  endtask

  task automatic rand_tick(input bit en, input bit qry);
    int unsigned k;
    k = $urandom_range(POOL - 1);
    if (en && $urandom_range(3) == 0) tick(1'b1, pool_p[k], pool_l[k], qry, pool_p[0], pool_l[0]);
    else tick(1'b0, '0, '0, qry, pool_p[k], pool_l[k]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic check_reset_outputs();
    check("rst_rejected", bus.rejected, 1'b0);
    check("rst_start", bus.start_send_to_pit, 1'b0);
    check("rst_data_out", bus.data_out, 8'h00);
    check("rst_data_valid", bus.data_out_valid, 1'b0);
    check("rst_data_last", bus.data_out_last, 1'b0);
    check("rst_table_full", table_full, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_reject_count", reject_count, 16'h0000);
    check("rst_interest_ready", bus.interest_ready, 1'b1);
  endtask

  task automatic query(input logic [PREFIX_W-1:0] qp, input logic [LEN_W-1:0] ql, input bit rnd,
                       input bit race, input int unsigned abort_at, input bit poke, input bit seq);
    int          exp_idx;
    int unsigned edges;
    int unsigned seen;
    int unsigned n;
    bit          done;
    bit          aborted;
    bit          any_pulse;
    seq_mode = seq;
    tick(1'b0, '0, '0, 1'b1, qp, ql);
    exp_idx = model_find(qp, ql);
    edges = 1;
    if (race) begin
      tick(1'b1, qp, ql, 1'b0, '0, '0);
      edges++;
    end
    while (!(bus.rejected || bus.start_send_to_pit) && edges < 8) begin
      rand_tick(rnd, 1'b0);
      edges++;
    end
    check("resp_latency", 64'(edges), 64'd3);
    check("start_pulse", bus.start_send_to_pit, exp_idx >= 0);
    check("rejected_pulse", bus.rejected, exp_idx < 0);
    if (exp_idx < 0) begin
      m_rejects++;
      rand_tick(rnd, 1'b0);
      check("rejected_one_cycle", bus.rejected, 1'b0);
      check("busy_after_reject", busy, 1'b0);
      check("reject_count", reject_count, exp_rc());
    end else begin
      rand_tick(rnd, 1'b0);
      check("start_one_cycle", bus.start_send_to_pit, 1'b0);
      seen = 0; n = 0; done = 1'b0; aborted = 1'b0;
      while (n < DATA_BYTES + 8) begin
        if (bus.data_out_valid) seen++;
        if (bus.data_out_last) begin done = 1'b1; break; end
        if (abort_at != 0 && seen == abort_at) begin aborted = 1'b1; break; end
        rand_tick(rnd, poke && (n % 97 == 5));
        n++;
      end
      if (aborted) begin
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end else if (done) begin
        m_valid[exp_idx] = 1'b0;
        check("bytes_forwarded", 64'(seen), 64'(DATA_BYTES));
        check("busy_after_xfer", busy, 1'b0);
        if (poke) begin
          any_pulse = 1'b0;
          repeat (4) begin
            tick(1'b0, '0, '0, 1'b0, '0, '0);
            any_pulse |= bus.rejected | bus.start_send_to_pit;
          end
          check("poke_ignored", any_pulse, 1'b0);
        end
      end else begin
        check("transfer_done", 1'b0, 1'b1);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.interest_valid = 1'b0; bus.interest_prefix = '0; bus.interest_len = '0;
    bus.prefix_ready = 1'b0; bus.fib_prefix = '0; bus.fib_len = '0; bus.fib_data = '0;
    for (int i = 0; i < POOL; i++) begin
      pool_p[i] = (i % 2 == 1) ? pool_p[i-1] : {$urandom, $urandom};
      pool_l[i] = 6'(i * 5 + 1);
    end
    model_clear();
    #1 rst = 1'b1;
    #2 check_reset_outputs();
    do_reset();

    // Single interest, sequential payload, slot retired
    tick(1'b1, 64'hA5A5_0000_0000_0000, 6'd16, 1'b0, '0, '0);
    check("one_entry_not_full", table_full, 1'b0);
    query(64'hA5A5_0000_0000_0000, 6'd16, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    check("cleared_not_full", table_full, 1'b0);
    query(64'hA5A5_0000_0000_0000, 6'd16, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Empty-table reject
    do_reset();
    query(64'h1234, 6'd8, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Fill, drop 9th, refill freed slot
    do_reset();
    for (int i = 0; i < ENTRIES; i++) tick(1'b1, 64'hF000 + 64'(i), 6'(i + 1), 1'b0, '0, '0);
    check("full_flag", table_full, 1'b1);
    check("full_ready", bus.interest_ready, 1'b0);
    tick(1'b1, 64'hF0FF, 6'd9, 1'b0, '0, '0);
    query(64'hF0FF, 6'd9, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    query(64'hF003, 6'd4, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    check("freed_not_full", table_full, 1'b0);
    tick(1'b1, 64'hBEEF, 6'd7, 1'b0, '0, '0);
    check("refill_full", table_full, 1'b1);
    query(64'hBEEF, 6'd7, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Aggregation of identical interests
    do_reset();
    tick(1'b1, 64'hCAFE, 6'd12, 1'b0, '0, '0);
    tick(1'b1, 64'hCAFE, 6'd12, 1'b0, '0, '0);
    for (int i = 0; i < ENTRIES - 2; i++) tick(1'b1, 64'hD000 + 64'(i), 6'd3, 1'b0, '0, '0);
    check("agg_not_full", table_full, 1'b0);
    query(64'hCAFE, 6'd12, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    query(64'hCAFE, 6'd12, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Reset at byte 500, then reject
    do_reset();
    tick(1'b1, 64'h5555, 6'd20, 1'b0, '0, '0);
    query(64'h5555, 6'd20, 1'b0, 1'b0, 500, 1'b0, 1'b0);
    check("post_abort_ready", bus.interest_ready, 1'b1);
    query(64'h5555, 6'd20, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // prefix_ready pulses during RECEIVE are ignored
    tick(1'b1, 64'h7777, 6'd33, 1'b0, '0, '0);
    query(64'h7777, 6'd33, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    // Insert landing on the LOOKUP edge is invisible to that lookup
    query(64'h9999, 6'd9, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    query(64'h9999, 6'd9, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Randomized traffic with concurrent inserts
    do_reset();
    for (int it = 0; it < 16; it++) begin
      int unsigned k;
      repeat ($urandom_range(6, 1)) begin
        k = $urandom_range(POOL - 1);
        tick(1'b1, pool_p[k], pool_l[k], 1'b0, '0, '0);
      end
      check("rand_full_flag", table_full, model_free() < 0);
      k = $urandom_range(POOL - 1);
      query(pool_p[k], pool_l[k], 1'b1, 1'b0, 0, 1'(it % 4 == 1), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
